// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: packed read ports, two write ports and hazard status.
// The master drives addresses and write data; the slave (the register file) returns data and status.
interface regfile_mp_if #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_READ = 2
);
   logic [NUM_READ*ADDR_W-1:0] read_regs;
   logic [NUM_READ*DATA_W-1:0] read_data;
   logic [ADDR_W-1:0]          write_reg_a;
   logic [DATA_W-1:0]          write_data_a;
   logic                       regWrite_a;
   logic [ADDR_W-1:0]          write_reg_b;
   logic [DATA_W-1:0]          write_data_b;
   logic                       regWrite_b;
   logic                       write_conflict;
   logic [15:0]                write_count;

   modport master (
      output read_regs, write_reg_a, write_data_a, regWrite_a,
             write_reg_b, write_data_b, regWrite_b,
      input  read_data, write_conflict, write_count
   );

   modport slave (
      input  read_regs, write_reg_a, write_data_a, regWrite_a,
             write_reg_b, write_data_b, regWrite_b,
      output read_data, write_conflict, write_count
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_READ combinational reads, two write ports (B wins on collision),
// optional write-to-read bypass, optional hardwired zero register, collision flag and write counter.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_READ = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input logic         clk,
   input logic         rst,
   regfile_mp_if.slave bus
);
   localparam int DEPTH = 2**ADDR_W;

   if (NUM_READ < 1 || NUM_READ > 8) begin : g_bad_num_read
      $error("regfile_mp: NUM_READ must be in 1..8");
   end

   logic [DATA_W-1:0]          mem_q [DEPTH];
   logic [DATA_W-1:0]          mem_d [DEPTH];
   logic                       write_conflict_q, write_conflict_d;
   logic [15:0]                write_count_q, write_count_d;
   logic                       eff_a, eff_b;
   logic [1:0]                 num_written;
   logic [16:0]                count_sum;
   logic [NUM_READ*DATA_W-1:0] read_data_w;

   // A write to register 0 is dropped entirely when it is hardwired, so it neither collides nor counts.
   assign eff_a = bus.regWrite_a && !(ZERO_REG != 0 && bus.write_reg_a == '0);
   assign eff_b = bus.regWrite_b && !(ZERO_REG != 0 && bus.write_reg_b == '0);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      mem_d = mem_q;
      if (eff_a) mem_d[bus.write_reg_a] = bus.write_data_a;
      if (eff_b) mem_d[bus.write_reg_b] = bus.write_data_b;
   end

   always_comb begin
      write_conflict_d = eff_a && eff_b && (bus.write_reg_a == bus.write_reg_b);
      num_written      = 2'({1'b0, eff_a} + {1'b0, eff_b} - {1'b0, write_conflict_d});
      count_sum        = {1'b0, write_count_q} + 17'(num_written);
      write_count_d    = count_sum[16] ? 16'hFFFF : count_sum[15:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: storage is reset deliberately so that every register reads a defined 0 after reset.
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         write_conflict_q <= 1'b0;
         write_count_q    <= '0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
         mem_q            <= mem_d;
         write_conflict_q <= write_conflict_d;
         write_count_q    <= write_count_d;
      end
   end

   for (genvar g = 0; g < NUM_READ; g++) begin : g_read
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;

      assign addr = bus.read_regs[g*ADDR_W +: ADDR_W];

      // Bypass order matches commit order, so B shadows A exactly as it does in storage.
      always_comb begin
         data = mem_q[addr];
         if (BYPASS != 0 && !rst) begin
            if (eff_a && addr == bus.write_reg_a) data = bus.write_data_a;
            if (eff_b && addr == bus.write_reg_b) data = bus.write_data_b;
         end
         if (ZERO_REG != 0 && addr == '0) data = '0;
      end

      assign read_data_w[g*DATA_W +: DATA_W] = data;
   end

   assign bus.read_data      = read_data_w;
   assign bus.write_conflict = write_conflict_q;
   assign bus.write_count    = write_count_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: four instances (default, no bypass, no zero register, four read
// ports) share one stimulus stream; each task checks its own scenario against hand-computed values.
module tb_regfile_mp;
   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rd [4];
   logic [4:0]  wa, wb;
   logic [31:0] wda, wdb;
   logic        wea, web;
   int          passed = 0;
   int          total  = 0;

   always #5 clk = ~clk;

   regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2)) if_def ();
   regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2)) if_nb ();
   regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2)) if_nz ();
   regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_READ(4)) if_r4 ();

   assign if_def.read_regs    = {rd[1], rd[0]};
   assign if_def.write_reg_a  = wa;
   assign if_def.write_data_a = wda;
   assign if_def.regWrite_a   = wea;
   assign if_def.write_reg_b  = wb;
   assign if_def.write_data_b = wdb;
   assign if_def.regWrite_b   = web;

   assign if_nb.read_regs    = {rd[1], rd[0]};
   assign if_nb.write_reg_a  = wa;
   assign if_nb.write_data_a = wda;
   assign if_nb.regWrite_a   = wea;
   assign if_nb.write_reg_b  = wb;
   assign if_nb.write_data_b = wdb;
   assign if_nb.regWrite_b   = web;

   assign if_nz.read_regs    = {rd[1], rd[0]};
   assign if_nz.write_reg_a  = wa;
   assign if_nz.write_data_a = wda;
   assign if_nz.regWrite_a   = wea;
   assign if_nz.write_reg_b  = wb;
   assign if_nz.write_data_b = wdb;
   assign if_nz.regWrite_b   = web;

   assign if_r4.read_regs    = {rd[3], rd[2], rd[1], rd[0]};
   assign if_r4.write_reg_a  = wa;
   assign if_r4.write_data_a = wda;
   assign if_r4.regWrite_a   = wea;
   assign if_r4.write_reg_b  = wb;
   assign if_r4.write_data_b = wdb;
   assign if_r4.regWrite_b   = web;

   regfile_mp #(.NUM_READ(2))              u_def (.clk(clk), .rst(rst), .bus(if_def));
   regfile_mp #(.NUM_READ(2), .BYPASS(0))   u_nb  (.clk(clk), .rst(rst), .bus(if_nb));
   regfile_mp #(.NUM_READ(2), .ZERO_REG(0)) u_nz  (.clk(clk), .rst(rst), .bus(if_nz));
   regfile_mp #(.NUM_READ(4))              u_r4  (.clk(clk), .rst(rst), .bus(if_r4));

   task automatic drive_idle();
      wea = 1'b0; wa = '0; wda = '0;
      web = 1'b0; wb = '0; wdb = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_idle();
      for (int i = 0; i < 4; i++) rd[i] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int a = 0; a < 32; a++) begin
         rd[0] = 5'(a);
         rd[1] = 5'(a);
         #1;
         total++;
         if (if_def.read_data[31:0] !== 32'd0) $display("FAIL reset_p0 addr %0d: got %h expected 0", a, if_def.read_data[31:0]);
         else passed++;
         total++;
         if (if_def.read_data[63:32] !== 32'd0) $display("FAIL reset_p1 addr %0d: got %h expected 0", a, if_def.read_data[63:32]);
         else passed++;
      end
      total++;
      if (if_def.write_conflict !== 1'b0) $display("FAIL reset_conflict: got %b expected 0", if_def.write_conflict);
      else passed++;
      total++;
      if (if_def.write_count !== 16'd0) $display("FAIL reset_count: got %0d expected 0", if_def.write_count);
      else passed++;
   endtask

   task automatic test_bypass();
      @(negedge clk);
      wea = 1'b1; wa = 5'd1; wda = 32'd55;
      rd[0] = 5'd0; rd[1] = 5'd1;
      #1;
      total++;
      if (if_def.read_data[63:32] !== 32'd55) $display("FAIL bypass_pre: got %0d expected 55", if_def.read_data[63:32]);
      else passed++;
      total++;
      if (if_nb.read_data[63:32] !== 32'd0) $display("FAIL nobypass_pre: got %0d expected 0", if_nb.read_data[63:32]);
      else passed++;
      @(posedge clk);
      #1 drive_idle();
      #1;
      total++;
      if (if_def.read_data[63:32] !== 32'd55) $display("FAIL bypass_post: got %0d expected 55", if_def.read_data[63:32]);
      else passed++;
      total++;
      if (if_nb.read_data[63:32] !== 32'd55) $display("FAIL nobypass_post: got %0d expected 55", if_nb.read_data[63:32]);
      else passed++;
      total++;
      if (if_def.write_count !== 16'd1) $display("FAIL bypass_count: got %0d expected 1", if_def.write_count);
      else passed++;
   endtask

   task automatic test_zero_reg();
      @(negedge clk);
      wea = 1'b1; wa = 5'd0; wda = 32'h1234_5678;
      web = 1'b1; wb = 5'd0; wdb = 32'hDEAD_BEEF;
      rd[0] = 5'd0;
      #1;
      total++;
      if (if_def.read_data[31:0] !== 32'd0) $display("FAIL zero_pre: got %h expected 0", if_def.read_data[31:0]);
      else passed++;
      total++;
      if (if_nz.read_data[31:0] !== 32'hDEAD_BEEF) $display("FAIL nozero_pre: got %h expected deadbeef", if_nz.read_data[31:0]);
      else passed++;
      @(posedge clk);
      #1 drive_idle();
      #1;
      total++;
      if (if_def.read_data[31:0] !== 32'd0) $display("FAIL zero_post: got %h expected 0", if_def.read_data[31:0]);
      else passed++;
      total++;
      if (if_def.write_count !== 16'd1) $display("FAIL zero_count: got %0d expected 1", if_def.write_count);
      else passed++;
      total++;
      if (if_def.write_conflict !== 1'b0) $display("FAIL zero_conflict: got %b expected 0", if_def.write_conflict);
      else passed++;
      total++;
      if (if_nz.read_data[31:0] !== 32'hDEAD_BEEF) $display("FAIL nozero_post: got %h expected deadbeef", if_nz.read_data[31:0]);
      else passed++;
      total++;
      if (if_nz.write_count !== 16'd2) $display("FAIL nozero_count: got %0d expected 2", if_nz.write_count);
      else passed++;
      total++;
      if (if_nz.write_conflict !== 1'b1) $display("FAIL nozero_conflict: got %b expected 1", if_nz.write_conflict);
      else passed++;
   endtask

   task automatic test_conflict();
      @(negedge clk);
      wea = 1'b1; wa = 5'd7; wda = 32'h11;
      web = 1'b1; wb = 5'd7; wdb = 32'h22;
      rd[0] = 5'd7;
      #1;
      total++;
      if (if_def.read_data[31:0] !== 32'h22) $display("FAIL collide_bypass: got %h expected 22", if_def.read_data[31:0]);
      else passed++;
      total++;
      if (if_nb.read_data[31:0] !== 32'h0) $display("FAIL collide_nobypass_pre: got %h expected 0", if_nb.read_data[31:0]);
      else passed++;
      @(posedge clk);
      #1 drive_idle();
      #1;
      total++;
      if (if_nb.read_data[31:0] !== 32'h22) $display("FAIL collide_data: got %h expected 22", if_nb.read_data[31:0]);
      else passed++;
      total++;
      if (if_def.write_conflict !== 1'b1) $display("FAIL collide_flag: got %b expected 1", if_def.write_conflict);
      else passed++;
      total++;
      if (if_def.write_count !== 16'd2) $display("FAIL collide_count: got %0d expected 2", if_def.write_count);
      else passed++;
      @(posedge clk);
      #1;
      total++;
      if (if_def.write_conflict !== 1'b0) $display("FAIL collide_flag_clear: got %b expected 0", if_def.write_conflict);
      else passed++;

      @(negedge clk);
      wea = 1'b1; wa = 5'd3; wda = 32'h33;
      web = 1'b1; wb = 5'd4; wdb = 32'h44;
      @(posedge clk);
      #1 drive_idle();
      rd[0] = 5'd3; rd[1] = 5'd4;
      #1;
      total++;
      if (if_nb.read_data[31:0] !== 32'h33) $display("FAIL pair_a: got %h expected 33", if_nb.read_data[31:0]);
      else passed++;
      total++;
      if (if_nb.read_data[63:32] !== 32'h44) $display("FAIL pair_b: got %h expected 44", if_nb.read_data[63:32]);
      else passed++;
      total++;
      if (if_def.write_conflict !== 1'b0) $display("FAIL pair_flag: got %b expected 0", if_def.write_conflict);
      else passed++;
      total++;
      if (if_def.write_count !== 16'd4) $display("FAIL pair_count: got %0d expected 4", if_def.write_count);
      else passed++;
   endtask

   task automatic test_multi_read();
      @(negedge clk);
      wea = 1'b1; wa = 5'd1; wda = 32'd10;
      web = 1'b1; wb = 5'd2; wdb = 32'd20;
      @(negedge clk);
      wa = 5'd3; wda = 32'd30;
      wb = 5'd4; wdb = 32'd40;
      @(posedge clk);
      #1 drive_idle();
      rd[0] = 5'd4; rd[1] = 5'd3; rd[2] = 5'd2; rd[3] = 5'd1;
      #1;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (if_r4.read_data[i*32 +: 32] !== 32'((4 - i) * 10))
            $display("FAIL multi_port%0d: got %0d expected %0d", i, if_r4.read_data[i*32 +: 32], (4 - i) * 10);
         else passed++;
      end
      for (int i = 0; i < 4; i++) rd[i] = 5'd2;
      #1;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (if_r4.read_data[i*32 +: 32] !== 32'd20)
            $display("FAIL dup_port%0d: got %0d expected 20", i, if_r4.read_data[i*32 +: 32]);
         else passed++;
      end
      total++;
      if (if_r4.write_count !== 16'd8) $display("FAIL multi_count: got %0d expected 8", if_r4.write_count);
      else passed++;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      wea = 1'b1; wa = 5'd5; wda = 32'h5A;
      rd[0] = 5'd5; rd[1] = 5'd6;
      @(posedge clk);
      #1 drive_idle();
      #1;
      total++;
      if (if_def.read_data[31:0] !== 32'h5A) $display("FAIL midrst_written: got %h expected 5a", if_def.read_data[31:0]);
      else passed++;
      #1;
      rst = 1'b1;
      wea = 1'b1; wa = 5'd6; wda = 32'h66;
      #1;
      total++;
      if (if_def.read_data[31:0] !== 32'h0) $display("FAIL midrst_cleared: got %h expected 0", if_def.read_data[31:0]);
      else passed++;
      total++;
      if (if_def.read_data[63:32] !== 32'h0) $display("FAIL midrst_no_bypass: got %h expected 0", if_def.read_data[63:32]);
      else passed++;
      total++;
      if (if_def.write_count !== 16'd0) $display("FAIL midrst_count: got %0d expected 0", if_def.write_count);
      else passed++;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      drive_idle();
      @(posedge clk);
      #1;
      total++;
      if (if_def.read_data[63:32] !== 32'h0) $display("FAIL midrst_blocked: got %h expected 0", if_def.read_data[63:32]);
      else passed++;
      total++;
      if (if_def.write_count !== 16'd0) $display("FAIL midrst_count_after: got %0d expected 0", if_def.write_count);
      else passed++;
      total++;
      if (if_def.write_conflict !== 1'b0) $display("FAIL midrst_conflict: got %b expected 0", if_def.write_conflict);
      else passed++;
   endtask

   task automatic test_saturation();
      rst = 1'b1;
      #1;
      @(negedge clk);
      rst = 1'b0;
      wea = 1'b1; wa = 5'd1; wda = 32'd1;
      web = 1'b1; wb = 5'd2; wdb = 32'd2;
      repeat (32767) @(posedge clk);
      #1;
      total++;
      if (if_def.write_count !== 16'hFFFE) $display("FAIL sat_below: got %h expected fffe", if_def.write_count);
      else passed++;
      @(posedge clk);
      #1;
      total++;
      if (if_def.write_count !== 16'hFFFF) $display("FAIL sat_clip: got %h expected ffff", if_def.write_count);
      else passed++;
      @(posedge clk);
      #1;
      total++;
      if (if_def.write_count !== 16'hFFFF) $display("FAIL sat_hold: got %h expected ffff", if_def.write_count);
      else passed++;
      drive_idle();
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_zero_reg();
      test_conflict();
      test_multi_read();
      test_reset_mid();
      test_saturation();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file for the MIPS pipeline and successor to the 2-read/1-write register file. Widths and depth are configurable. It provides NUM_READ combinational read ports, two write ports (A for WB, B for a second retire slot), optional same-cycle write-to-read bypass, and a hardwired zero register. It also flags write-port collisions for the hazard unit.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_READ, 2, number of read ports (1..8)
BYPASS, 1, 1 = read of a register being written this cycle returns the new data
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous, active-high reset
read_regs  in  NUM_READ*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W]
read_data  out  NUM_READ*DATA_W  packed read data; port i = bits [i*DATA_W +: DATA_W]
write_reg_a  in  ADDR_W  write address, port A
write_data_a  in  DATA_W  write data, port A
regWrite_a  in  1  write enable, port A
write_reg_b  in  ADDR_W  write address, port B
write_data_b  in  DATA_W  write data, port B
regWrite_b  in  1  write enable, port B
write_conflict  out  1  registered: previous edge had A and B writing the same effective register
write_count  out  16  registered count of effective writes committed since reset, saturating

Behaviour:
- Reset (rst=1, asynchronous):
  - all 2**ADDR_W registers clear to 0; write_conflict=0; write_count=0.
  - Writes are blocked while rst=1.
  - Deassertion takes effect at the next rising edge.
  - Reset mid-operation discards that cycle's writes.
- Effective write X (X in {A,B}): regWrite_x=1 and NOT(ZERO_REG=1 and write_reg_x=0).
- Commit: on rising clk, each effective write updates its register. Port B takes priority over A when addresses match.
- Read (combinational, zero latency):
  - read_data[i] = mem[read_regs[i]].
  - If ZERO_REG=1 and the address is 0, the output is 0 regardless of storage.
  - If BYPASS=1, the address matches an effective write this cycle, and rst=0, the output is that write's data, with B over A.
  - If BYPASS=0, the read shows the old value until after the edge.
- All read ports are independent; any port may read any address, duplicates included.
- write_conflict: at each rising edge it takes 1 if both A and B are effective and write_reg_a==write_reg_b, else 0. It holds for exactly the following cycle.
- write_count:
  - increments at each rising edge by the number of distinct registers written (0, 1 or 2). A colliding A/B pair counts as 1.
  - saturates at 16'hFFFF and never wraps.
- Out-of-range parameters (NUM_READ=0 or >8) are a static elaboration error.
- No X propagation: uninitialised state is impossible because reset clears everything.

Test Plan:
1. Assert rst, release; read all 32 addresses on 2 ports -> read_data all 0, write_conflict=0, write_count=0.
2. regWrite_a=1, write_reg_a=1, write_data_a=32'd55, read_regs port1=1 in the same cycle:
   - BYPASS=1 -> read_data port1=55 before the edge; after the edge, still 55 with regWrite_a=0; write_count=1.
   - Rerun with BYPASS=0 -> port1 reads 0 before the edge, 55 after.
3. Write 32'hDEADBEEF to reg 0 via A -> port0 reading reg 0 returns 0, write_count unchanged. Rerun with ZERO_REG=0 -> returns 32'hDEADBEEF.
4. A writes reg 7 = 32'h11 and B writes reg 7 = 32'h22 in the same cycle -> reg 7 = 32'h22, write_conflict=1 for one cycle then 0, write_count +1. A=reg 3, B=reg 4 -> both written, write_conflict=0, write_count +2.
5. Set NUM_READ=4 and write regs 1..4 with 10,20,30,40; read ports 0..3 = {4,3,2,1} -> read_data = {40,30,20,10} per port. Duplicate address on all ports -> identical data.
6. Pulse rst asynchronously mid-cycle after writing reg 5 = 32'h5A -> reg 5 reads 0 immediately; a write enabled during rst is not committed; write_count=0.
